// File: rtl/mmio_data_memory.sv
// Word-addressed data memory with a memory-mapped IO window at the low addresses.
// IO accesses are strobed out and held until acknowledged or the wait budget runs out.
module mmio_data_memory #(
    parameter int               DW         = 32,
    parameter int               AW         = 8,
    parameter int               IO_NUM     = 16,
    parameter logic [IO_NUM-1:0] IO_WR_MASK = 16'h0045,
    parameter logic [IO_NUM-1:0] IO_RD_MASK = 16'h07BA,
    parameter int               TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    output logic [DW-1:0]   rdata,
    output logic            ready,
    output logic            err,
    output logic [AW-1:0]   io_addr,
    output logic [DW-1:0]   io_dout,
    output logic            io_we,
    output logic            io_rd,
    input  logic [DW-1:0]   io_din,
    input  logic            io_ack,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    localparam int NB  = DW / 8;
    localparam int IOW = (IO_NUM > 1) ? $clog2(IO_NUM) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [AW-1:0]     io_addr_q, io_addr_d;
    logic [DW-1:0]     io_dout_q, io_dout_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic [DW-1:0]     mem [2**AW];

    logic              is_io;
    logic              io_legal;

    assign is_io    = (addr < AW'(IO_NUM));
    assign io_legal = we ? IO_WR_MASK[addr[IOW-1:0]] : IO_RD_MASK[addr[IOW-1:0]];

    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no path infers a latch.
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        io_addr_d = io_addr_q;
        io_dout_d = io_dout_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (!is_io) begin
                        state_d = MEM;
                    end else if (io_legal) begin
                        state_d   = IO;
                        io_addr_d = addr;
                        tmo_d     = '0;
                        if (we) io_dout_d = wdata;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            MEM: begin
                if (!we_q) rdata_d = mem[addr_q];
                err_d   = 1'b0;
                state_d = RESP;
            end
            IO: begin
                if (io_ack) begin
                    if (!we_q) rdata_d = io_din;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            io_addr_q <= '0;
            io_dout_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            io_addr_q <= io_addr_d;
            io_dout_q <= io_dout_d;
            tmo_q     <= tmo_d;
        end
    end

    // NOTE: the array has no reset so contents survive rstn; a write aborted by reset never reaches MEM.
    always_ff @(posedge clk) begin
        if (state_q == MEM && we_q) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_q[b]) mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    assign rdata    = rdata_q;
    assign err      = err_q;
    assign ready    = (state_q == RESP);
    assign io_addr  = io_addr_q;
    assign io_dout  = io_dout_q;
    assign io_we    = (state_q == IO) &&  we_q;
    assign io_rd    = (state_q == IO) && !we_q;
    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_mmio_data_memory.sv
// Scoreboard bench for mmio_data_memory: expected responses are queued at issue
// and compared when ready pulses; latency, IO strobes and reset abort are checked inline.
module tb_mmio_data_memory;

    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            req, we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic [DW-1:0]   rdata;
    logic            ready, err;
    logic [AW-1:0]   io_addr;
    logic [DW-1:0]   io_dout;
    logic            io_we, io_rd;
    logic [DW-1:0]   io_din;
    logic            io_ack;
    logic [AW-1:0]   dbg_addr;
    logic [DW-1:0]   dbg_data;

    mmio_data_memory dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .err(err), .io_addr(io_addr),
        .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din),
        .io_ack(io_ack), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_rd;
    } resp_t;

    resp_t         sb_q[$];
    logic [DW-1:0] model [int];
    logic [DW-1:0] last_rdata;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [DW/8-1:0] ws);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW/8; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic access(input string name, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW/8-1:0] ws,
                          input int ack_at, input logic [DW-1:0] din,
                          input int exp_lat, input int exp_io, input resp_t exp);
        int    lat;
        int    io_cyc;
        bit    done;
        resp_t r;
        sb_q.push_back(exp);
        req = 1'b1; we = w; addr = a; wdata = wd; wstrb = ws; io_din = din;
        @(posedge clk); #1;
        req = 1'b0; wdata = '0; addr = '0;
        lat = 0; io_cyc = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready) begin
                done = 1'b1;
                io_ack = 1'b0;
                r = sb_q.pop_front();
                check({name, "_err"}, err, r.err);
                if (r.chk_rd) check({name, "_rdata"}, rdata, r.rdata);
                check({name, "_latency"}, lat, exp_lat);
                check({name, "_io_cycles"}, io_cyc, exp_io);
            end else if (io_we || io_rd) begin
                io_cyc++;
                check({name, "_io_dir"}, {io_we, io_rd}, {w, ~w});
                check({name, "_io_addr"}, io_addr, a);
                if (w) check({name, "_io_dout"}, io_dout, wd);
                io_ack = (io_cyc == ack_at);
            end
        end
        check({name, "_ready_seen"}, done, 1'b1);
        if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
        @(posedge clk); #1;
        check({name, "_ready_pulse"}, ready, 1'b0);
        if (exp.chk_rd) check({name, "_rdata_hold"}, rdata, exp.rdata);
    endtask

    task automatic mem_write(input string name, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [DW/8-1:0] ws);
        resp_t e;
        model[int'(a)] = merge(model.exists(int'(a)) ? model[int'(a)] : '0, wd, ws);
        e = '{rdata: last_rdata, err: 1'b0, chk_rd: 1'b1};
        access(name, 1'b1, a, wd, ws, 0, '0, 2, 0, e);
        dbg_addr = a;
        #1 check({name, "_dbg"}, dbg_data, model[int'(a)]);
    endtask

    task automatic mem_read(input string name, input logic [AW-1:0] a);
        resp_t e;
        e = '{rdata: model[int'(a)], err: 1'b0, chk_rd: 1'b1};
        last_rdata = model[int'(a)];
        access(name, 1'b0, a, '0, '0, 0, '0, 2, 0, e);
    endtask

    initial begin
        resp_t         e;
        logic [AW-1:0] ra;
        checks = 0; errors = 0; last_rdata = '0;
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        io_din = '0; io_ack = 1'b0; dbg_addr = '0;
        #12;
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_io_addr", io_addr, '0);
        check("rst_io_dout", io_dout, '0);
        check("rst_io_strobes", {io_we, io_rd}, 2'b00);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        mem_write("wr_full", 8'h20, 32'hDEADBEEF, 4'hF);
        mem_read("rd_full", 8'h20);
        mem_write("wr_part", 8'h20, 32'h11223344, 4'b0101);
        mem_read("rd_part", 8'h20);
        check("part_const", model[32'h20], 32'hDE22BE44);
        mem_write("wr_nostrb", 8'h20, 32'hFFFFFFFF, 4'h0);
        mem_read("rd_nostrb", 8'h20);
        mem_write("wr_top", 8'hFF, 32'hA5A5_0F0F, 4'hF);
        mem_read("rd_top", 8'hFF);
        mem_write("wr_first", 8'h10, 32'h0BAD_F00D, 4'hF);
        mem_read("rd_first", 8'h10);

        for (int i = 0; i < 6; i++) begin
            ra = AW'($urandom_range(17, 254));
            mem_write($sformatf("rnd%0d_wf", i), ra, DW'($urandom), 4'hF);
            mem_write($sformatf("rnd%0d_wp", i), ra, DW'($urandom), 4'($urandom_range(1, 14)));
            mem_read($sformatf("rnd%0d_rd", i), ra);
        end

        e = '{rdata: last_rdata, err: 1'b0, chk_rd: 1'b1};
        access("io_wr2", 1'b1, 8'd2, 32'h5A, 4'h0, 3, '0, 4, 3, e);
        e = '{rdata: 32'h1234, err: 1'b0, chk_rd: 1'b1};
        access("io_rd4", 1'b0, 8'd4, '0, 4'h0, 1, 32'h1234, 2, 1, e);
        last_rdata = 32'h1234;
        e = '{rdata: '0, err: 1'b1, chk_rd: 1'b0};
        access("io_wr1_illegal", 1'b1, 8'd1, 32'h77, 4'hF, 1, '0, 1, 0, e);
        access("io_rd0_illegal", 1'b0, 8'd0, '0, 4'h0, 1, 32'h99, 1, 0, e);
        e = '{rdata: '0, err: 1'b1, chk_rd: 1'b1};
        access("io_rd7_timeout", 1'b0, 8'd7, '0, 4'h0, 0, '0, 16, 15, e);
        last_rdata = '0;

        io_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ack_ready", ready, 1'b0);
        end
        io_ack = 1'b0;
        @(posedge clk); #1;

        req = 1'b1; we = 1'b0; addr = 8'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("pre_rst_io_rd", io_rd, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("rst_io_rd_drop", io_rd, 1'b0);
        check("rst_io_addr_clr", io_addr, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_ready", ready, 1'b0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        mem_read("rd_after_io_rst", 8'h20);

        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        @(posedge clk); #2;
        req = 1'b0;
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mem_no_ready", ready, 1'b0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        mem_read("rd_after_mem_rst", 8'h20);
        dbg_addr = 8'h20;
        #1 check("dbg_after_rst", dbg_data, model[32'h20]);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
